// File: rtl/conn_lookup_arbiter.sv
// Round-robin arbiter that shares one hash/connection-table lookup unit between
// NUM_REQ packet-rewrite lanes and routes each result (or a timeout) to its lane.
module conn_lookup_arbiter #(
    parameter int NUM_REQ  = 2,
    parameter int HASH_LEN = 16,
    parameter int TIMEOUT  = 64
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [NUM_REQ*128-1:0] req_tuple_i,
    input  logic [NUM_REQ-1:0]     req_valid_i,
    output logic [NUM_REQ-1:0]     req_ready_o,
    output logic [15:0]            resp_data_o,
    output logic                   resp_err_o,
    output logic [NUM_REQ-1:0]     resp_valid_o,
    output logic [127:0]           tuple_data_o,
    output logic                   tuple_valid_o,
    input  logic [15:0]            conn_data_i,
    input  logic                   conn_valid_i,
    output logic [15:0]            timeout_cnt_o
);

    localparam int GW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CW = $clog2(TIMEOUT);

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t          state;
    logic [GW-1:0]   last_grant;
    logic [GW-1:0]   grant_idx;
    logic [CW-1:0]   wait_cnt;
    logic [GW-1:0]   winner;
    logic            any_req;
    logic [127:0]    sel_tuple;

    // NOTE: every variable assigned in always_comb gets a default first, so no latch is inferred.
    always_comb begin
        winner  = '0;
        any_req = 1'b0;
        // Offset 1 is the lane right after the last grant, giving rotating priority.
        for (int i = 1; i <= NUM_REQ; i++) begin
            for (int j = 0; j < NUM_REQ; j++) begin
                if (!any_req && req_valid_i[j] && ((int'(last_grant) + i) % NUM_REQ) == j) begin
                    any_req = 1'b1;
                    winner  = GW'(j);
                end
            end
        end
    end

    always_comb begin
        sel_tuple = '0;
        for (int j = 0; j < NUM_REQ; j++) begin
            if (winner == GW'(j)) sel_tuple = req_tuple_i[128*j +: 128];
        end
    end

    assign req_ready_o = (state == IDLE && any_req) ? (NUM_REQ'(1) << winner) : '0;

    // NOTE: all sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= IDLE;
            last_grant    <= GW'(NUM_REQ - 1);
            grant_idx     <= '0;
            wait_cnt      <= '0;
            tuple_valid_o <= 1'b0;
            tuple_data_o  <= '0;
            resp_valid_o  <= '0;
            resp_data_o   <= '0;
            resp_err_o    <= 1'b0;
            timeout_cnt_o <= '0;
        end else begin
            case (state)
                IDLE: begin
                    resp_valid_o <= '0;
                    if (any_req) begin
                        tuple_data_o  <= sel_tuple;
                        grant_idx     <= winner;
                        wait_cnt      <= '0;
                        tuple_valid_o <= 1'b1;
                        state         <= WAIT;
                    end
                end
                WAIT: begin
                    wait_cnt <= wait_cnt + 1'b1;
                    // A result arriving on the timeout cycle takes precedence over the error.
                    if (conn_valid_i) begin
                        resp_data_o   <= 16'(conn_data_i[HASH_LEN-1:0]);
                        resp_err_o    <= 1'b0;
                        resp_valid_o  <= NUM_REQ'(1) << grant_idx;
                        tuple_valid_o <= 1'b0;
                        state         <= RESP;
                    end else if (wait_cnt == CW'(TIMEOUT - 1)) begin
                        resp_data_o   <= '0;
                        resp_err_o    <= 1'b1;
                        resp_valid_o  <= NUM_REQ'(1) << grant_idx;
                        tuple_valid_o <= 1'b0;
                        if (timeout_cnt_o != 16'hFFFF) timeout_cnt_o <= timeout_cnt_o + 16'd1;
                        state         <= RESP;
                    end
                end
                RESP: begin
                    resp_valid_o <= '0;
                    last_grant   <= grant_idx;
                    state        <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_conn_lookup_arbiter.sv
// Directed scoreboard bench for conn_lookup_arbiter: two lanes, TIMEOUT=8, HASH_LEN=6.
module tb_conn_lookup_arbiter;

    localparam int NUM_REQ  = 2;
    localparam int HASH_LEN = 6;
    localparam int TIMEOUT  = 8;

    logic                   clk = 1'b0;
    logic                   reset;
    logic [NUM_REQ*128-1:0] req_tuple_i;
    logic [NUM_REQ-1:0]     req_valid_i;
    logic [NUM_REQ-1:0]     req_ready_o;
    logic [15:0]            resp_data_o;
    logic                   resp_err_o;
    logic [NUM_REQ-1:0]     resp_valid_o;
    logic [127:0]           tuple_data_o;
    logic                   tuple_valid_o;
    logic [15:0]            conn_data_i;
    logic                   conn_valid_i;
    logic [15:0]            timeout_cnt_o;

    conn_lookup_arbiter #(.NUM_REQ(NUM_REQ), .HASH_LEN(HASH_LEN), .TIMEOUT(TIMEOUT)) dut (
        .clk           (clk),
        .reset         (reset),
        .req_tuple_i   (req_tuple_i),
        .req_valid_i   (req_valid_i),
        .req_ready_o   (req_ready_o),
        .resp_data_o   (resp_data_o),
        .resp_err_o    (resp_err_o),
        .resp_valid_o  (resp_valid_o),
        .tuple_data_o  (tuple_data_o),
        .tuple_valid_o (tuple_valid_o),
        .conn_data_i   (conn_data_i),
        .conn_valid_i  (conn_valid_i),
        .timeout_cnt_o (timeout_cnt_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          lane;
        logic [15:0] data;
        logic        err;
    } exp_t;

    exp_t sb[$];
    int   vectors     = 0;
    int   miscompares = 0;

    localparam logic [127:0] T0 = {24'h0, 32'h0A000001, 32'hC0A80001, 16'd1234, 16'd80, 8'h06};
    localparam logic [127:0] T1 = {24'h0, 32'h0A000002, 32'h08080808, 16'd5555, 16'd53, 8'h11};

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    task automatic push(input int lane, input logic [15:0] data, input logic err);
        exp_t e;
        e.lane = lane;
        e.data = data;
        e.err  = err;
        sb.push_back(e);
    endtask

    // Waits up to budget cycles for a response strobe, then checks it against the scoreboard head.
    task automatic wait_resp(input string tag, input int budget);
        int   n = 0;
        exp_t e;
        while (resp_valid_o === '0 && n < budget) begin
            step();
            n++;
        end
        check({tag, "_seen"}, 128'(resp_valid_o != '0), 128'(1));
        if (resp_valid_o !== '0) begin
            if (sb.size() == 0) begin
                check({tag, "_unexpected"}, 128'(resp_valid_o), 128'(0));
            end else begin
                e = sb.pop_front();
                check({tag, "_lane"}, 128'(resp_valid_o), 128'(NUM_REQ'(1) << e.lane));
                check({tag, "_data"}, 128'(resp_data_o), 128'(e.data));
                check({tag, "_err"},  128'(resp_err_o),  128'(e.err));
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int cnt;
        reset        = 1'b1;
        req_tuple_i  = {T1, T0};
        req_valid_i  = '0;
        conn_data_i  = '0;
        conn_valid_i = 1'b0;
        step();
        step();
        reset = 1'b0;
        #1;
        check("rst_ready",   128'(req_ready_o),   128'(0));
        check("rst_tvalid",  128'(tuple_valid_o), 128'(0));
        check("rst_tdata",   tuple_data_o,        128'(0));
        check("rst_rvalid",  128'(resp_valid_o),  128'(0));
        check("rst_rdata",   128'(resp_data_o),   128'(0));
        check("rst_rerr",    128'(resp_err_o),    128'(0));
        check("rst_tocnt",   128'(timeout_cnt_o), 128'(0));

        // Single lane lookup, answered two cycles after tuple_valid rises.
        step();
        req_valid_i = 2'b01;
        #1;
        check("single_ready", 128'(req_ready_o), 128'(2'b01));
        step();
        req_valid_i = '0;
        check("single_tvalid", 128'(tuple_valid_o), 128'(1));
        check("single_tdata",  tuple_data_o, T0);
        check("single_ready_wait", 128'(req_ready_o), 128'(0));
        push(0, 16'h002A, 1'b0);
        step();
        conn_valid_i = 1'b1;
        conn_data_i  = 16'h002A;
        step();
        conn_valid_i = 1'b0;
        wait_resp("single", 0);
        check("single_tvalid_off", 128'(tuple_valid_o), 128'(0));
        step();
        check("single_strobe_1cyc", 128'(resp_valid_o), 128'(0));
        check("single_hold", 128'(resp_data_o), 128'(16'h002A));

        // Contention: both lanes requesting from reset, one-cycle lookup unit.
        req_valid_i = 2'b11;
        reset = 1'b1;
        step();
        reset = 1'b0;
        for (int k = 0; k < 4; k++) begin
            #1;
            check($sformatf("cont%0d_ready", k), 128'(req_ready_o), 128'(2'b01 << (k % 2)));
            step();
            check($sformatf("cont%0d_tdata", k), tuple_data_o, (k % 2 == 0) ? T0 : T1);
            conn_valid_i = 1'b1;
            conn_data_i  = 16'(k + 1);
            push(k % 2, 16'(k + 1), 1'b0);
            step();
            conn_valid_i = 1'b0;
            wait_resp($sformatf("cont%0d", k), 0);
            step();
        end
        req_valid_i = '0;

        // Timeout with no answer from the lookup unit.
        step();
        req_valid_i = 2'b10;
        #1;
        check("to_ready", 128'(req_ready_o), 128'(2'b10));
        push(1, 16'h0000, 1'b1);
        step();
        req_valid_i = '0;
        cnt = 0;
        while (tuple_valid_o === 1'b1 && cnt < 20) begin
            cnt++;
            step();
        end
        check("to_tvalid_cycles", 128'(cnt), 128'(TIMEOUT));
        wait_resp("to", 0);
        check("to_count", 128'(timeout_cnt_o), 128'(1));
        step();
        step();
        conn_valid_i = 1'b1;
        conn_data_i  = 16'h0011;
        step();
        conn_valid_i = 1'b0;
        check("to_stale_rvalid", 128'(resp_valid_o), 128'(0));
        check("to_stale_tvalid", 128'(tuple_valid_o), 128'(0));
        step();
        check("to_stale_rvalid2", 128'(resp_valid_o), 128'(0));

        // Result arrives exactly on the timeout cycle.
        req_valid_i = 2'b01;
        #1;
        check("sim_ready", 128'(req_ready_o), 128'(2'b01));
        step();
        req_valid_i = '0;
        repeat (TIMEOUT - 1) step();
        check("sim_tvalid_last", 128'(tuple_valid_o), 128'(1));
        conn_valid_i = 1'b1;
        conn_data_i  = 16'h0005;
        push(0, 16'h0005, 1'b0);
        step();
        conn_valid_i = 1'b0;
        wait_resp("sim", 0);
        check("sim_count", 128'(timeout_cnt_o), 128'(1));
        step();

        // Reset while waiting on the lookup unit.
        req_valid_i = 2'b10;
        #1;
        check("mid_ready", 128'(req_ready_o), 128'(2'b10));
        step();
        req_valid_i = '0;
        step();
        check("mid_tvalid", 128'(tuple_valid_o), 128'(1));
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("mid_tvalid_rst", 128'(tuple_valid_o), 128'(0));
        check("mid_tdata_rst",  tuple_data_o,        128'(0));
        check("mid_rdata_rst",  128'(resp_data_o),   128'(0));
        check("mid_rerr_rst",   128'(resp_err_o),    128'(0));
        check("mid_tocnt_rst",  128'(timeout_cnt_o), 128'(0));
        check("mid_rvalid_rst", 128'(resp_valid_o),  128'(0));
        conn_valid_i = 1'b1;
        conn_data_i  = 16'h1234;
        step();
        conn_valid_i = 1'b0;
        check("mid_late_rvalid", 128'(resp_valid_o), 128'(0));
        check("mid_late_tvalid", 128'(tuple_valid_o), 128'(0));
        step();
        check("mid_late_rvalid2", 128'(resp_valid_o), 128'(0));

        // Both lanes after reset: lane 0 wins; HASH_LEN truncation of the result.
        req_valid_i = 2'b11;
        #1;
        check("post_rst_ready", 128'(req_ready_o), 128'(2'b01));
        step();
        req_valid_i = '0;
        check("post_rst_tdata", tuple_data_o, T0);
        conn_valid_i = 1'b1;
        conn_data_i  = 16'hFFFF;
        push(0, 16'h003F, 1'b0);
        step();
        conn_valid_i = 1'b0;
        wait_resp("hash", 0);
        step();

        check("sb_drained", 128'(sb.size()), 128'(0));
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/conn_lookup_arbiter.md
Name: conn_lookup_arbiter

Overview:
Shares the single hash/connection-table lookup unit between NUM_REQ packet-rewrite lanes. Each lane presents a 5-tuple and waits for its connection ID. The arbiter grants lanes round-robin and runs one lookup at a time. It drives the tuple to the lookup unit and returns the connection ID, or a timeout error, to the granted lane only. It sits between the lane parsers and the hash unit, and replaces the direct parser-to-hash tuple/conn wiring.

Parameters:
NUM_REQ, 2, number of requesting lanes (2..4)
HASH_LEN, 16, width of connection ID returned by the lookup unit (<=16)
TIMEOUT, 64, max cycles in WAIT before error response (>=2)

Ports:
clk  input  1  clock, all logic on rising edge
reset  input  1  synchronous, active-high reset
req_tuple_i  input  NUM_REQ*128  per-lane tuple {24'h0, src_ip, dst_ip, src_port, dst_port, protocol}; lane k at [128k+127:128k]
req_valid_i  input  NUM_REQ  per-lane lookup request, held until accepted
req_ready_o  output  NUM_REQ  per-lane accept; handshake when valid&ready
resp_data_o  output  16  connection ID, shared by all lanes, zero-extended from HASH_LEN
resp_err_o  output  1  1 = timed out, resp_data_o = 0
resp_valid_o  output  NUM_REQ  one-cycle response strobe to granted lane only
tuple_data_o  output  128  tuple to lookup unit
tuple_valid_o  output  1  lookup request to lookup unit, level, held while waiting
conn_data_i  input  16  connection ID from lookup unit (low HASH_LEN bits used)
conn_valid_i  input  1  lookup result strobe
timeout_cnt_o  output  16  saturating count of timed-out lookups

Behaviour:
- States: IDLE, WAIT, RESP.
- Reset while reset=1 at an edge, including mid-lookup:
  - state=IDLE, last_grant=NUM_REQ-1 so lane 0 has first priority;
  - tuple_valid_o=0, tuple_data_o=0, resp_valid_o=0, resp_data_o=0, resp_err_o=0, timeout_cnt_o=0, wait counter=0;
  - any in-flight lookup is abandoned and a late conn_valid_i is ignored.
- req_ready_o is combinational. In IDLE, exactly one bit is high: the winning lane. All bits are 0 in every other state.
- Winner selection: first lane with req_valid_i=1, scanning from (last_grant+1) mod NUM_REQ upward with wrap.
- IDLE:
  - no request -> stay;
  - on a request -> latch the winner's tuple into tuple_data_o and store its index g, clear the wait counter, go to WAIT;
  - tuple_valid_o=1 from the next cycle.
- WAIT:
  - tuple_valid_o=1, tuple_data_o stable, wait counter increments each cycle.
  - conn_valid_i=1 -> latch conn_data_i[HASH_LEN-1:0] into resp_data_o, set resp_err_o=0, go to RESP.
  - Counter reaches TIMEOUT-1 with conn_valid_i=0 -> resp_data_o=0, resp_err_o=1, timeout_cnt_o += 1 (saturate at 16'hFFFF), go to RESP.
  - conn_valid_i on the timeout cycle -> the valid response wins and no error is raised.
  - tuple_valid_o=0 from the cycle after leaving WAIT.
- RESP:
  - resp_valid_o[g]=1 for exactly one cycle, all other bits 0;
  - resp_data_o and resp_err_o stay valid in that cycle and hold until the next RESP;
  - last_grant=g, next state IDLE.
- conn_valid_i outside WAIT is ignored. A stale result after a timeout never reaches any lane.
- Latency:
  - request accepted at cycle T -> tuple_valid_o high at T+1;
  - conn_valid_i at cycle C -> resp_valid_o at C+1;
  - minimum 3 cycles per lookup (lookup unit answering in its first WAIT cycle).
- Fairness: a lane that is continuously requesting is granted within NUM_REQ lookups.
- Lane contract: tuple stable while req_valid_i=1 and not yet accepted. The arbiter samples it only on the handshake cycle.
- The only storage is the latched tuple, so at most one lookup is outstanding.

Test Plan:
- Single lane: lane0 requests tuple {24'h0, 32'h0A000001, 32'hC0A80001, 16'd1234, 16'd80, 8'h06}; lookup unit returns conn_data_i=16'h002A two cycles after tuple_valid_o rises -> req_ready_o=2'b01 in the request cycle, tuple_data_o matches the request, resp_valid_o=2'b01 one cycle after conn_valid_i, resp_data_o=16'h002A, resp_err_o=0.
- Contention: both lanes hold req_valid_i from reset, lookup unit answers in 1 cycle -> grant order 0,1,0,1 over 4 lookups, and each resp_valid_o strobe goes only to the granted lane.
- Timeout: TIMEOUT=8, lookup unit never answers -> tuple_valid_o high exactly 8 cycles, resp_valid_o pulse with resp_err_o=1 and resp_data_o=0, timeout_cnt_o=1. A conn_valid_i pulse 2 cycles later produces no resp_valid_o.
- Simultaneous: conn_valid_i=1 with conn_data_i=16'h0005 exactly on the timeout cycle -> resp_err_o=0, resp_data_o=16'h0005, timeout_cnt_o unchanged.
- Reset mid-WAIT: reset=1 for one cycle while tuple_valid_o=1 -> next cycle tuple_valid_o=0 and all outputs 0. A subsequent conn_valid_i is ignored, and the next request with both lanes valid is granted to lane 0.
- HASH_LEN=6: conn_data_i=16'hFFFF -> resp_data_o=16'h003F.
